lector_registro: RTL and testbench

Sequential read-out initiator for the 32×32 register file. On a start pulse it walks a contiguous, wrapping range of register addresses over the register file's combinational read port. Each word is returned on a valid/ready stream. Sits between the register file's first read port (dirlec1/datolec1) and a debug/trace consumer; the register file itself is unchanged.

---
 rtl/lector_registro_if.sv | 31 +++
 rtl/lector_registro.sv | 157 +++++++++++++++
 tb/tb_lector_registro.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lector_registro_if.sv
// Signal bundle for lector_registro: the register-file read port, the start/abort
// controls, status flags, and the outgoing valid/ready word stream.
interface lector_registro_if #(
    parameter int NREG  = 32,
    parameter int ANCHO = 32
);
    localparam int AW = $clog2(NREG);

    logic             inicio;
    logic             abortar;
    logic [AW-1:0]    dirini;
    logic [AW:0]      cuenta;
    logic [AW-1:0]    dirlec;
    logic [ANCHO-1:0] datolec;
    logic [ANCHO-1:0] dato_sal;
    logic             valido;
    logic             listo;
    logic             ultimo;
    logic             ocupado;
    logic             fin;

    modport master (
        input  inicio, abortar, dirini, cuenta, datolec, listo,
        output dirlec, dato_sal, valido, ultimo, ocupado, fin
    );

    modport slave (
        output inicio, abortar, dirini, cuenta, datolec, listo,
        input  dirlec, dato_sal, valido, ultimo, ocupado, fin
    );
endinterface

// File: rtl/lector_registro.sv
// Walks a wrapping register range over the read port; first word valid 2 cycles after inicio, at most 1 word/2 cycles.
// Word and ultimo are held while listo=0. LECTOR_CHECKSUM_EN appends an XOR checksum word.
module lector_registro #(
    parameter int NREG  = 32,
    parameter int ANCHO = 32
) (
    input  logic               clk,
    input  logic               reset,
    lector_registro_if.master  bus
);
    localparam int            AW   = $clog2(NREG);
    localparam logic [AW:0]   NMAX = (AW+1)'(NREG);
    localparam logic [AW:0]   UNO  = (AW+1)'(1);
    localparam logic [AW-1:0] DMAX = AW'(NREG - 1);

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        LEER   = 3'd1,
        ENVIAR = 3'd2,
`ifdef LECTOR_CHECKSUM_EN
        SUMA   = 3'd3,
`endif
        FIN    = 3'd4
    } estado_t;

    estado_t          estado, estado_nx;
    logic [AW-1:0]    dir, dir_nx;
    logic [AW:0]      resto, resto_nx;
    logic [ANCHO-1:0] dato_r, dato_nx;
    logic             valido_r, valido_nx;
    logic             ultimo_r, ultimo_nx;
    logic [AW:0]      cuenta_ef;
    logic [AW-1:0]    dir_sig;
`ifdef LECTOR_CHECKSUM_EN
    logic [ANCHO-1:0] cks, cks_nx;
`endif

    // A count of zero, or anything past the file size, reads the whole file once.
    assign cuenta_ef = (bus.cuenta == '0 || bus.cuenta > NMAX) ? NMAX : bus.cuenta;
    assign dir_sig   = (dir == DMAX) ? '0 : dir + AW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado   <= REPOSO;
            dir      <= '0;
            resto    <= '0;
            dato_r   <= '0;
            valido_r <= 1'b0;
            ultimo_r <= 1'b0;
`ifdef LECTOR_CHECKSUM_EN
            cks      <= '0;
`endif
        end else begin
            estado   <= estado_nx;
            dir      <= dir_nx;
            resto    <= resto_nx;
            dato_r   <= dato_nx;
            valido_r <= valido_nx;
            ultimo_r <= ultimo_nx;
`ifdef LECTOR_CHECKSUM_EN
            cks      <= cks_nx;
`endif
        end
    end

    always_comb begin
        estado_nx = estado;
        dir_nx    = dir;
        resto_nx  = resto;
        dato_nx   = dato_r;
        valido_nx = valido_r;
        ultimo_nx = ultimo_r;
`ifdef LECTOR_CHECKSUM_EN
        cks_nx    = cks;
`endif
        unique case (estado)
            REPOSO: begin
                if (bus.inicio) begin
                    dir_nx    = bus.dirini;
                    resto_nx  = cuenta_ef;
`ifdef LECTOR_CHECKSUM_EN
                    cks_nx    = '0;
`endif
                    estado_nx = LEER;
                end
            end
            LEER: begin
                if (bus.abortar) begin
                    valido_nx = 1'b0;
                    ultimo_nx = 1'b0;
                    estado_nx = FIN;
                end else begin
                    dato_nx   = bus.datolec;
                    valido_nx = 1'b1;
`ifdef LECTOR_CHECKSUM_EN
                    ultimo_nx = 1'b0;
                    cks_nx    = cks ^ bus.datolec;
`else
                    ultimo_nx = (resto == UNO);
`endif
                    estado_nx = ENVIAR;
                end
            end
            ENVIAR: begin
                // Abort wins over a handshake in the same cycle: the word is dropped and dir stays put.
                if (bus.abortar) begin
                    valido_nx = 1'b0;
                    ultimo_nx = 1'b0;
                    estado_nx = FIN;
                end else if (bus.listo) begin
                    valido_nx = 1'b0;
                    ultimo_nx = 1'b0;
                    dir_nx    = dir_sig;
                    resto_nx  = resto - UNO;
                    if (resto == UNO) begin
`ifdef LECTOR_CHECKSUM_EN
                        dato_nx   = cks;
                        valido_nx = 1'b1;
                        ultimo_nx = 1'b1;
                        estado_nx = SUMA;
`else
                        estado_nx = FIN;
`endif
                    end else begin
                        estado_nx = LEER;
                    end
                end
            end
`ifdef LECTOR_CHECKSUM_EN
            SUMA: begin
                if (bus.abortar || bus.listo) begin
                    valido_nx = 1'b0;
                    ultimo_nx = 1'b0;
                    estado_nx = FIN;
                end
            end
`endif
            FIN: begin
                valido_nx = 1'b0;
                ultimo_nx = 1'b0;
                estado_nx = REPOSO;
            end
            default: begin
                valido_nx = 1'b0;
                ultimo_nx = 1'b0;
                estado_nx = REPOSO;
            end
        endcase
    end

    assign bus.dirlec   = dir;
    assign bus.dato_sal = dato_r;
    assign bus.valido   = valido_r;
    assign bus.ultimo   = ultimo_r;
    assign bus.ocupado  = (estado != REPOSO);
    assign bus.fin      = (estado == FIN);
endmodule

// File: tb/tb_lector_registro.sv
// Directed bench for lector_registro: behavioural register file, scoreboard of expected stream words.
module tb_lector_registro;
    localparam int ANCHO = 32;
`ifdef LECTOR_CHECKSUM_EN
    localparam int CKX = 1;
`else
    localparam int CKX = 0;
`endif

    typedef struct packed {
        logic [ANCHO-1:0] d;
        logic             u;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [ANCHO-1:0] brr [32];
    exp_t sb [$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lector_registro_if #(.NREG(32), .ANCHO(ANCHO)) bus ();

    lector_registro #(.NREG(32), .ANCHO(ANCHO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.datolec = brr[bus.dirlec];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [ANCHO-1:0] d, input logic u);
        exp_t e;
        e.d = d;
        e.u = u;
        return e;
    endfunction

    // Every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && bus.valido && bus.listo && !bus.abortar) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("word_dato", bus.dato_sal, mon_e.d);
                chk("word_ultimo", bus.ultimo, mon_e.u);
            end
        end
    end

    task automatic expect_burst(input logic [4:0] di, input int n);
        logic [ANCHO-1:0] x;
        logic [4:0] a;
        x = '0;
        for (int i = 0; i < n; i++) begin
            a = 5'(di + i);
            sb.push_back(mk(brr[a], (i == n - 1) && (CKX == 0)));
            x = x ^ brr[a];
        end
        if (CKX == 1) sb.push_back(mk(x, 1'b1));
    endtask

    task automatic start(input logic [4:0] di, input logic [5:0] cu);
        bus.dirini = di;
        bus.cuenta = cu;
        bus.inicio = 1'b1;
        @(posedge clk); #1;
        bus.inicio = 1'b0;
    endtask

    // Counts cycles from the current one until fin is seen (0 on timeout).
    task automatic wait_fin(output int n, output int vc, output int oc);
        bit done;
        n = 0; vc = 0; oc = 0; done = 0;
        for (int k = 1; k <= 300 && !done; k++) begin
            @(negedge clk);
            if (bus.valido)  vc++;
            if (bus.ocupado) oc++;
            if (bus.fin) begin
                n = k;
                done = 1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic burst(input string tag, input logic [4:0] di, input logic [5:0] cu, input int n);
        int f, vc, oc;
        expect_burst(di, n);
        start(di, cu);
        wait_fin(f, vc, oc);
        chk({tag, "_fin_cycle"}, f, 2 * n + 1 + CKX);
        chk({tag, "_valido_cycles"}, vc, n + CKX);
        chk({tag, "_ocupado_cycles"}, oc, 2 * n + 1 + CKX);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_dirlec_next"}, bus.dirlec, 5'(di + n));
        chk({tag, "_ocupado_after"}, bus.ocupado, 1'b0);
    endtask

    initial begin
        int f, vc, oc, nf;
        reset       = 1'b1;
        bus.inicio  = 1'b0;
        bus.abortar = 1'b0;
        bus.dirini  = '0;
        bus.cuenta  = '0;
        bus.listo   = 1'b1;
        for (int k = 0; k < 32; k++) brr[k] = 32'(k) * 32'h0101_0101;

        #12;
        chk("rst_valido", bus.valido, 1'b0);
        chk("rst_dato", bus.dato_sal, '0);
        chk("rst_dirlec", bus.dirlec, '0);
        chk("rst_ultimo", bus.ultimo, 1'b0);
        chk("rst_ocupado", bus.ocupado, 1'b0);
        chk("rst_fin", bus.fin, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        burst("basic", 5'd3, 6'd4, 4);
        burst("wrap", 5'd30, 6'd4, 4);
        burst("cnt0", 5'd5, 6'd0, 32);
        burst("cnt40", 5'd17, 6'd40, 32);
        burst("single", 5'd31, 6'd1, 1);

        // Stall word 2 for five cycles.
        expect_burst(5'd10, 4);
        start(5'd10, 6'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.listo = 1'b0;
        @(posedge clk); #1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_valido", bus.valido, 1'b1);
            chk("stall_dato", bus.dato_sal, 32'h0B0B_0B0B);
            chk("stall_ultimo", bus.ultimo, 1'b0);
            chk("stall_dirlec", bus.dirlec, 5'd11);
            @(posedge clk); #1;
        end
        bus.listo = 1'b1;
        @(posedge clk); #1;
        chk("stall_dir_once", bus.dirlec, 5'd12);
        chk("stall_valido_drop", bus.valido, 1'b0);
        wait_fin(f, vc, oc);
        chk("stall_fin_cycle", f, 5 + CKX);
        chk("stall_sb_empty", sb.size(), 0);

        // Abort together with the handshake of word 2.
        sb.push_back(mk(brr[20], 1'b0));
        start(5'd20, 6'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_w2_valido", bus.valido, 1'b1);
        bus.abortar = 1'b1;
        @(posedge clk); #1;
        bus.abortar = 1'b0;
        chk("abort_valido_drop", bus.valido, 1'b0);
        chk("abort_fin", bus.fin, 1'b1);
        chk("abort_dirlec", bus.dirlec, 5'd21);
        @(posedge clk); #1;
        chk("abort_fin_once", bus.fin, 1'b0);
        chk("abort_ocupado", bus.ocupado, 1'b0);
        vc = 0; nf = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.valido) vc++;
            if (bus.fin) nf++;
            @(posedge clk); #1;
        end
        chk("abort_no_words", vc, 0);
        chk("abort_no_fin", nf, 0);
        chk("abort_sb_empty", sb.size(), 0);

`ifdef LECTOR_CHECKSUM_EN
        brr[8] = 32'hA5A5_A5A5;
        brr[9] = 32'h0F0F_0F0F;
        sb.push_back(mk(32'hA5A5_A5A5, 1'b0));
        sb.push_back(mk(32'h0F0F_0F0F, 1'b0));
        sb.push_back(mk(32'hAAAA_AAAA, 1'b1));
        start(5'd8, 6'd2);
        wait_fin(f, vc, oc);
        chk("cks_fin_cycle", f, 6);
        chk("cks_valido_cycles", vc, 3);
        chk("cks_sb_empty", sb.size(), 0);
`endif

        // Reset in the middle of a burst.
        start(5'd12, 6'd4);
        @(posedge clk); #1;
        chk("midrst_valido_pre", bus.valido, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_valido", bus.valido, 1'b0);
        chk("midrst_dato", bus.dato_sal, '0);
        chk("midrst_dirlec", bus.dirlec, '0);
        chk("midrst_ultimo", bus.ultimo, 1'b0);
        chk("midrst_ocupado", bus.ocupado, 1'b0);
        chk("midrst_fin", bus.fin, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        nf = 0; oc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.fin) nf++;
            if (bus.ocupado) oc++;
            @(posedge clk); #1;
        end
        chk("midrst_no_fin", nf, 0);
        chk("midrst_idle", oc, 0);
        chk("midrst_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
